// File: rtl/global_defines.sv
`ifndef GLOBAL_DEFINES_SV
`define GLOBAL_DEFINES_SV
`define MAX_EMBEDDING_DIM 8
`define INTEGER_WIDTH 32
`endif

// File: rtl/vec_pack.sv
// vec_pack: ping-pong packer turning an element stream into whole vectors; ports clk/rst, vld_in/rdy_out/elem_in upstream, vld_out/rdy_in/vec_out downstream
`include "global_defines.sv"
module vec_pack #(
  parameter int VEC_LEN = `MAX_EMBEDDING_DIM,
  parameter int DATA_WIDTH = `INTEGER_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_in,
  output logic                  rdy_out,
  input  logic [DATA_WIDTH-1:0] elem_in,
  output logic                  vld_out,
  input  logic                  rdy_in,
  output logic [DATA_WIDTH-1:0] vec_out [VEC_LEN]
);
  localparam int IW = VEC_LEN > 1 ? $clog2(VEC_LEN) : 1;
  logic [DATA_WIDTH-1:0] bank [2][VEC_LEN];
  logic [1:0] full;
  logic wr_bank, rd_bank;
  logic [IW-1:0] wr_idx;
  logic el_xfer, vec_xfer, last;
  assign el_xfer = vld_in && rdy_out;
  assign vec_xfer = vld_out && rdy_in;
  assign last = wr_idx == IW'(VEC_LEN - 1);
  assign rdy_out = !full[wr_bank];
  assign vld_out = full[rd_bank];
  always_comb vec_out = bank[rd_bank];
  // The write bank is never full when written and the read bank is never empty when
  // drained, so the set and clear masks below can never target the same flag at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < VEC_LEN; i++)
          bank[b][i] <= '0;
      full <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_idx <= '0;
    end else begin
      if (el_xfer) begin
        bank[wr_bank][wr_idx] <= elem_in;
        wr_idx <= last ? '0 : wr_idx + 1'b1;
        wr_bank <= wr_bank ^ last;
      end
      if (vec_xfer) rd_bank <= ~rd_bank;
      full <= (full & ~(vec_xfer ? 2'b01 << rd_bank : 2'b00))
            | (el_xfer && last ? 2'b01 << wr_bank : 2'b00);
    end
  end
endmodule

// File: tb/tb_vec_pack.sv
// tb_vec_pack: directed and scoreboarded checks of vec_pack with VEC_LEN=4, DATA_WIDTH=8
module tb_vec_pack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vld_in = 1'b0;
  logic rdy_out;
  logic [7:0] elem_in = '0;
  logic vld_out;
  logic rdy_in = 1'b0;
  logic [7:0] vec_out [4];
  int checks = 0;
  int failures = 0;
  vec_pack #(.VEC_LEN(4), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .vld_in(vld_in), .rdy_out(rdy_out), .elem_in(elem_in),
    .vld_out(vld_out), .rdy_in(rdy_in), .vec_out(vec_out)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] vp();
    return {vec_out[3], vec_out[2], vec_out[1], vec_out[0]};
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  logic [7:0] q[$];
  logic [31:0] prev, exp_v;
  logic held, take;
  int nv, acc, cyc;
  initial begin
    #12 rst = 1'b0;
    chk("reset_vld_out", 32'(vld_out), 32'd0);
    chk("reset_rdy_out", 32'(rdy_out), 32'd1);
    chk("reset_vec_out", vp(), 32'h0);
    // first vector with downstream always ready
    step();
    rdy_in = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      vld_in = 1'b1;
      elem_in = 8'(i);
      chk("first_rdy_out", 32'(rdy_out), 32'd1);
      step();
    end
    vld_in = 1'b0;
    chk("first_vld_out", 32'(vld_out), 32'd1);
    chk("first_vec", vp(), 32'h04030201);
    step();
    chk("first_drained", 32'(vld_out), 32'd0);
    // fill both banks while downstream stalls
    rdy_in = 1'b0;
    for (int i = 10; i <= 17; i++) begin
      vld_in = 1'b1;
      elem_in = 8'(i);
      step();
    end
    chk("both_full_rdy_out", 32'(rdy_out), 32'd0);
    chk("both_full_vld_out", 32'(vld_out), 32'd1);
    chk("both_full_vec", vp(), 32'h0D0C0B0A);
    elem_in = 8'd18;
    step();
    step();
    chk("stall_rdy_out", 32'(rdy_out), 32'd0);
    chk("stall_vec_stable", vp(), 32'h0D0C0B0A);
    // one-cycle drain frees a bank, 18 then lands at index 0
    rdy_in = 1'b1;
    step();
    rdy_in = 1'b0;
    chk("second_vec", vp(), 32'h11100F0E);
    chk("reopen_rdy_out", 32'(rdy_out), 32'd1);
    step();
    for (int i = 19; i <= 21; i++) begin
      elem_in = 8'(i);
      step();
    end
    vld_in = 1'b0;
    rdy_in = 1'b1;
    step();
    chk("third_vld_out", 32'(vld_out), 32'd1);
    chk("third_vec", vp(), 32'h15141312);
    step();
    chk("third_drained", 32'(vld_out), 32'd0);
    // continuous stream 0..31 with no bubbles
    nv = 0;
    for (int j = 0; j <= 32; j++) begin
      vld_in = j < 32;
      elem_in = 8'(j);
      if (j < 32) chk("stream_rdy_out", 32'(rdy_out), 32'd1);
      step();
      if (vld_out) begin
        exp_v = {8'(4 * nv + 3), 8'(4 * nv + 2), 8'(4 * nv + 1), 8'(4 * nv)};
        chk("stream_vec", vp(), exp_v);
        nv++;
      end
    end
    vld_in = 1'b0;
    chk("stream_count", 32'(nv), 32'd8);
    // reset in the middle of a partial fill
    rdy_in = 1'b0;
    vld_in = 1'b1;
    elem_in = 8'd5;
    step();
    elem_in = 8'd6;
    step();
    vld_in = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_vld_out", 32'(vld_out), 32'd0);
    chk("midrst_rdy_out", 32'(rdy_out), 32'd1);
    chk("midrst_vec", vp(), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 7; i <= 10; i++) begin
      vld_in = 1'b1;
      elem_in = 8'(i);
      step();
    end
    vld_in = 1'b0;
    chk("post_rst_vld_out", 32'(vld_out), 32'd1);
    chk("post_rst_vec", vp(), 32'h0A090807);
    rdy_in = 1'b1;
    step();
    // random handshakes against a scoreboard of accepted elements
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      vld_in = $urandom_range(0, 1) == 1;
      rdy_in = $urandom_range(0, 2) != 0;
      elem_in = 8'($urandom_range(0, 255));
      take = vld_out && rdy_in;
      if (take) begin
        if (q.size() >= 4) begin
          exp_v = {q[3], q[2], q[1], q[0]};
          repeat (4) void'(q.pop_front());
        end else exp_v = 32'hxxxxxxxx;
        chk("rand_vec", vp(), exp_v);
      end
      if (vld_in && rdy_out) begin
        q.push_back(elem_in);
        acc++;
      end
      held = vld_out && !rdy_in;
      prev = vp();
      step();
      cyc++;
      if (held) chk("rand_hold_stable", vp(), prev);
    end
    vld_in = 1'b0;
    chk("rand_accept_budget", 32'(acc >= 1000), 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
